pulse_measure: RTL
==================

# pulse_measure

Measures the timing of an external pulse relative to a trigger: on `start`, it counts clock cycles until the pulse's active edge (delay), then counts how long the pulse stays active (width). It is the receive-side counterpart to the EVR's programmable pulse outputs. Typical uses are loopback self-test and calibrating output cable and fan-out delays. The block sits beside the pulse outputs and reports through a one-cycle `valid` strobe with held result registers.

## Interface
- `CNT_W`, default 32: width of the delay, width and timeout counters.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `polarity` in 1: 0 = pulse is active-high; 1 = pulse is active-low.
- `start` in 1: arm trigger, one cycle or longer; level-sampled.
- `timeout` in CNT_W: abort limit in cycles, applied to each phase; 0 = no timeout.
- `pulse_in` in 1: pulse under measurement.
- `busy` out 1: high while a measurement is armed or in progress.
- `valid` out 1: one-cycle strobe when a new result is loaded.
- `meas_delay` out CNT_W: cycles from `start` to the active edge.
- `meas_wide` out CNT_W: active cycles of the pulse.
- `timed_out` out 1: the last result ended by timeout; held with the result.

## Operation
- Active level: `lvl = pulse_in XOR polarity`.
- Edge detect:
  - `lvl_d` is the registered `lvl`, updated every cycle in all states.
  - An edge is `lvl & !lvl_d`.
  - A pulse already active at arm time is ignored until it returns inactive.
- States are IDLE, WAIT_EDGE, IN_PULSE and DONE.
- IDLE:
  - `start` = 1 → WAIT_EDGE, with the delay counter cleared.
  - An edge in the same cycle as `start` is not counted.
- WAIT_EDGE:
  - The delay counter increments each cycle.
  - On an edge, `meas_delay` ← the number of cycles since the start cycle (N ≥ 1), and the state → IN_PULSE with the width counter = 1.
  - If `timeout` ≠ 0 and the delay counter reaches `timeout`, → DONE with `timed_out` = 1, `meas_delay` = `timeout` and `meas_wide` = 0.
- IN_PULSE:
  - The width counter increments for each active sample.
  - On the first inactive sample, `meas_wide` ← the count, then → DONE.
  - If `timeout` ≠ 0 and the width counter reaches `timeout`, → DONE with `timed_out` = 1 and `meas_wide` = `timeout`.
- DONE: `valid` = 1 for exactly one cycle, then → IDLE.
- `start` in WAIT_EDGE, IN_PULSE or DONE is ignored; there is no re-trigger.
- Counters saturate at 2^CNT_W−1 and never wrap. This only matters when `timeout` = 0.
- Results and `timed_out` hold until the next `valid`.

## Timing
- Reset clears all outputs and counters to 0 and forces IDLE; this includes a reset mid-measurement, which produces no `valid`.
- `busy` goes high the cycle after `start` is accepted and goes low in the cycle after DONE.
- Delay convention: an active `lvl` first sampled k cycles after the start cycle gives `meas_delay` = k.
- Width convention: W consecutive active samples give `meas_wide` = W.
- `valid` rises the cycle after the first inactive sample, or after the timeout cycle.
- Minimum spacing between two accepted `start`s: the next `start` may be accepted in the cycle after DONE.

## Configuration
- `PULSE_MEASURE_SYNC_EN` defined:
  - `pulse_in` passes through a two-flop synchronizer before polarity and edge logic.
  - `meas_delay` grows by exactly 2 for the same pin timing; `meas_wide` is unchanged.
  - `pulse_in` may be asynchronous.
- Not defined: `pulse_in` is used directly and must be synchronous to `clk`.

## Structure
- Shared package `pulse_measure_pkg` holds:
  - the state encoding constants (IDLE = 0, WAIT_EDGE = 1, IN_PULSE = 2, DONE = 3);
  - the default `CNT_W`;
  - the synchronizer depth constant (2).
- One sub-module, `pulse_edge_det`:
  - contains the optional synchronizer, polarity XOR and `lvl_d` register;
  - outputs `lvl` and `edge`.

## Test plan
- polarity = 0, timeout = 0; `start` at cycle 0, `pulse_in` high for cycles 10–14 → one `valid` with `meas_delay` = 10, `meas_wide` = 5, `timed_out` = 0. With `PULSE_MEASURE_SYNC_EN` defined, `meas_delay` = 12.
- polarity = 1; `pulse_in` low for cycles 3–3 after `start` → `meas_delay` = 3, `meas_wide` = 1.
- `pulse_in` already active during `start`, inactive at cycle 4, active again at cycles 7–8 → `meas_delay` = 7, `meas_wide` = 2.
- timeout = 20; no pulse → `valid` after 20 counted cycles with `timed_out` = 1, `meas_delay` = 20, `meas_wide` = 0. Then timeout = 20 with a pulse held high forever → `timed_out` = 1 and `meas_wide` = 20.
- A second `start` during IN_PULSE is ignored; exactly one `valid` occurs. A `start` in the cycle after DONE is accepted.
- `reset` asserted during WAIT_EDGE → no `valid`; all outputs 0; `busy` = 0 the next cycle.

Source files
------------

// File: rtl/pulse_measure_pkg.sv
// Shared constants for the pulse delay/width measurement block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pulse_measure_pkg;

    // Default width of the delay, width and timeout counters
    localparam int DEF_CNT_W = 32;

    // Depth of the optional input synchronizer
    localparam int SYNC_DEPTH = 2;

    // Measurement FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_IN_PULSE  = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_edge_det.sv
// Active-level and active-edge detect for the measured pulse; optional
// synchronizer when PULSE_MEASURE_SYNC_EN is defined (adds SYNC_DEPTH cycles).
// Backpressure: none, free-running every cycle.
module pulse_edge_det
    import pulse_measure_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic polarity,
    input  logic pulse_in,
    output logic lvl,
    output logic act_edge
);

    logic pin;
    logic lvl_d;

`ifdef PULSE_MEASURE_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync_q;

    // Two-flop synchronizer so an asynchronous pin can be measured safely
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pulse_in};
        end
    end

    assign pin = sync_q[SYNC_DEPTH-1];
`else
    assign pin = pulse_in;
`endif

    // Polarity applied after synchronization so the synchronizer sees the raw pin
    assign lvl = pin ^ polarity;

    // Previous active level, updated in every state so a pulse already
    // active at arm time produces no edge until it goes inactive first
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign act_edge = lvl & ~lvl_d;

endmodule

// File: rtl/pulse_measure.sv
// Measures start-to-edge delay and active width of pulse_in; optional input
// synchronizer via PULSE_MEASURE_SYNC_EN. Result is presented with a one-cycle valid
// strobe the cycle after the pulse ends or a timeout hits. No backpressure.
module pulse_measure
    import pulse_measure_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic             start,
    input  logic [CNT_W-1:0] timeout,
    input  logic             pulse_in,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_wide,
    output logic             timed_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             lvl;
    logic             act_edge;

    // One phase counter serves both phases: delay while waiting, width in the pulse
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    // Delay captured at the edge, kept private so outputs only change on valid
    logic [CNT_W-1:0] dly_cap;
    logic             to_en;
    logic             to_hit;
    logic             to_at_edge;

    pulse_edge_det u_edge (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .pulse_in (pulse_in),
        .lvl      (lvl),
        .act_edge (act_edge)
    );

    // Saturating increment and timeout comparisons shared by FSM and datapath
    always_comb begin
        cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        to_en      = (timeout != '0);
        to_hit     = to_en && (cnt_inc == timeout);
        // A width count of 1 already reaches a timeout of 1 on the edge itself
        to_at_edge = to_en && (timeout == CNT_ONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                if (act_edge) begin
                    state_nxt = to_at_edge ? ST_DONE : ST_IN_PULSE;
                end else if (to_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_IN_PULSE: begin
                if (!lvl || to_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy  = (state != ST_IDLE);
        valid = (state == ST_DONE);
    end

    // Counters and result registers; results load only on the way into DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            dly_cap    <= '0;
            meas_delay <= '0;
            meas_wide  <= '0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                end
                ST_WAIT_EDGE: begin
                    if (act_edge) begin
                        dly_cap <= cnt_inc;
                        cnt     <= CNT_ONE;
                        if (to_at_edge) begin
                            meas_delay <= cnt_inc;
                            meas_wide  <= CNT_ONE;
                            timed_out  <= 1'b1;
                        end
                    end else if (to_hit) begin
                        meas_delay <= timeout;
                        meas_wide  <= '0;
                        timed_out  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_IN_PULSE: begin
                    if (!lvl) begin
                        meas_delay <= dly_cap;
                        meas_wide  <= cnt;
                        timed_out  <= 1'b0;
                    end else if (to_hit) begin
                        meas_delay <= dly_cap;
                        meas_wide  <= timeout;
                        timed_out  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
